// File: rtl/imem_loader_pkg.sv
// Shared types and framing constants for the instruction-memory loader.
// Stream format: 2-byte big-endian word count followed by big-endian 32-bit words.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// 8->32 big-endian packer: word_vld pulses one cycle after the fourth byte shifts in.
// No backpressure of its own; the word stays on word_dat until the next byte shifts.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic        word_end,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] cnt;

  // High when the byte currently offered completes a word.
  assign word_end = (cnt == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else begin
      word_vld <= shift && word_end;
      if (clear) begin
        cnt <= '0;
      end else if (shift) begin
        word_dat <= {word_dat[23:0], din};
        cnt      <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the CPU.
// Each word is written one cycle after its last byte; in_ready depends only on state.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t            state;
  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [15:0]       rx_words;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       hdr_n;
  logic              xfer;
  logic              data_xfer;
  logic              start_ok;
  logic              word_end;

  assign in_ready  = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
  assign xfer      = in_valid && in_ready;
  assign data_xfer = xfer && (state == DATA);
  assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign hdr_n     = {len_hi, in_data};
  assign imem_addr = addr;

  byte_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_ok),
    .shift    (data_xfer),
    .din      (in_data),
    .word_end (word_end),
    .word_vld (imem_we),
    .word_dat (imem_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      len_hi       <= '0;
      len          <= '0;
      rx_words     <= '0;
      addr         <= '0;
      cpu_hold     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
    end else begin
      // Address and count advance as each write retires; a new start overrides below.
      if (imem_we) begin
        addr         <= addr + ADDR_W'(4);
        words_loaded <= words_loaded + 16'd1;
      end
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= LEN_HI;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            addr         <= '0;
            rx_words     <= '0;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            len_hi <= in_data;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            len <= hdr_n;
            if (hdr_n == 16'd0) begin
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else if ({1'b0, hdr_n} > MAX_N) begin
              state <= ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (data_xfer && word_end) begin
            rx_words <= rx_words + 16'd1;
            // Release the CPU in the same cycle the final word is strobed.
            if (rx_words == len - 16'd1) begin
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of loads checked against a word-list model plus corner sequences.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_loader #(.MAX_WORDS(256), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
    logic        hold;
    logic [15:0] wl;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [15:0] n;
    bit          use_spec;
    int          gap;       // 0 full rate, 1 toggle, 2 random idles
    logic        exp_done;
    logic        exp_err;
    logic [15:0] exp_wl;
  } vec_t;

  wr_t         wr_q[$];
  logic [31:0] exp_words[$];
  int          xfer_q[$];
  logic [31:0] spec_img[2];
  logic        prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      wr_t w;
      chk("strobe_width", {31'd0, prev_we}, 32'd0);
      w.addr = imem_addr; w.data = imem_wdata; w.done = done;
      w.hold = cpu_hold;  w.wl = words_loaded; w.cyc = cyc;
      wr_q.push_back(w);
    end
    prev_we = rst_n && imem_we;
  end

  task automatic push_byte(input logic [7:0] b);
    int guard = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    xfer_q.push_back(cyc);
    in_valid = 1'b0;
  endtask

  task automatic idle_gap(input int mode);
    int n;
    n = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic begin_load(input vec_t v);
    wr_q.delete();
    xfer_q.delete();
    exp_words.delete();
    if (v.n <= 16'd256)
      for (int k = 0; k < int'(v.n); k++)
        exp_words.push_back(v.use_spec ? spec_img[k % 2] : $urandom());
    pulse_start();
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_in_ready", {31'd0, in_ready}, 32'd1);
    chk("start_clears", {14'd0, done, error, words_loaded}, 32'd0);
    chk("start_hold", {31'd0, cpu_hold}, 32'd1);
  endtask

  task automatic push_word(input logic [31:0] w, input int gap);
    for (int j = 3; j >= 0; j--) begin
      push_byte(w[8*j +: 8]);
      idle_gap(gap);
    end
  endtask

  // Model: word k at address 4k, strobed in the cycle after its fourth byte.
  task automatic check_writes();
    int nexp;
    nexp = exp_words.size();
    chk("write_count", wr_q.size(), nexp);
    for (int k = 0; k < nexp && k < wr_q.size(); k++) begin
      chk("wr_addr", wr_q[k].addr, 32'(4 * k));
      chk("wr_data", wr_q[k].data, exp_words[k]);
      chk("wr_cycle", wr_q[k].cyc, xfer_q[HDR_BYTES + 4 * k + 3]);
      chk("wr_wl", {16'd0, wr_q[k].wl}, 32'(k));
      chk("wr_done", {31'd0, wr_q[k].done}, (k == nexp - 1) ? 32'd1 : 32'd0);
      chk("wr_hold", {31'd0, wr_q[k].hold}, (k == nexp - 1) ? 32'd0 : 32'd1);
    end
  endtask

  task automatic run_load(input vec_t v);
    begin_load(v);
    push_byte(v.n[15:8]);
    idle_gap(v.gap);
    push_byte(v.n[7:0]);
    if (v.n == 16'd0) begin
      chk("n0_done", {31'd0, done}, 32'd1);
      chk("n0_hold", {31'd0, cpu_hold}, 32'd0);
      chk("n0_busy", {31'd0, busy}, 32'd0);
    end else if (v.exp_err) begin
      chk("err_flag", {31'd0, error}, 32'd1);
      chk("err_busy", {31'd0, busy}, 32'd0);
      chk("err_in_ready", {31'd0, in_ready}, 32'd0);
      chk("err_hold", {31'd0, cpu_hold}, 32'd1);
    end else begin
      idle_gap(v.gap);
      for (int k = 0; k < exp_words.size(); k++) begin
        if (k == exp_words.size() - 1) begin
          for (int j = 3; j >= 0; j--) begin
            push_byte(exp_words[k][8*j +: 8]);
            if (j != 0) idle_gap(v.gap);
          end
        end else begin
          push_word(exp_words[k], v.gap);
        end
      end
      chk("last_we", {31'd0, imem_we}, 32'd1);
      chk("last_done", {31'd0, done}, 32'd1);
      chk("last_hold", {31'd0, cpu_hold}, 32'd0);
      chk("last_busy", {31'd0, busy}, 32'd0);
      chk("last_in_ready", {31'd0, in_ready}, 32'd0);
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("end_words_loaded", {16'd0, words_loaded}, {16'd0, v.exp_wl});
    chk("end_done", {31'd0, done}, {31'd0, v.exp_done});
    chk("end_error", {31'd0, error}, {31'd0, v.exp_err});
    chk("end_hold", {31'd0, cpu_hold}, {31'd0, v.exp_err});
    chk("end_we", {31'd0, imem_we}, 32'd0);
    check_writes();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_wl"}, {16'd0, words_loaded}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    vec_t spec_v;
    spec_img[0] = 32'h20080005;
    spec_img[1] = 32'h01095020;
    //            n         spec  gap done err wl
    vt[0] = '{16'd2,     1'b1, 0, 1'b1, 1'b0, 16'd2};
    vt[1] = '{16'd2,     1'b1, 1, 1'b1, 1'b0, 16'd2};
    vt[2] = '{16'd0,     1'b0, 0, 1'b1, 1'b0, 16'd0};
    vt[3] = '{16'h0101,  1'b0, 0, 1'b0, 1'b1, 16'd0};
    vt[4] = '{16'd1,     1'b0, 1, 1'b1, 1'b0, 16'd1};
    vt[5] = '{16'd256,   1'b0, 0, 1'b1, 1'b0, 16'd256};
    vt[6] = '{16'd257,   1'b0, 1, 1'b0, 1'b1, 16'd0};
    vt[7] = '{16'd5,     1'b0, 2, 1'b1, 1'b0, 16'd5};
    spec_v = vt[0];

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_load(vt[i]);

    // Reset asserted mid-load after six data bytes.
    begin_load(spec_v);
    push_byte(8'h00);
    push_byte(8'h02);
    for (int j = 0; j < 6; j++) push_byte(exp_words[j / 4][8*(3 - j % 4) +: 8]);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_load(spec_v);

    // start held during DATA must not disturb the load.
    begin_load(spec_v);
    push_byte(8'h00);
    push_byte(8'h02);
    for (int j = 0; j < 3; j++) push_byte(exp_words[0][8*(3 - j) +: 8]);
    start = 1'b1;
    push_byte(exp_words[0][7:0]);
    push_byte(exp_words[1][31:24]);
    chk("mid_start_busy", {31'd0, busy}, 32'd1);
    chk("mid_start_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_start_wl", {16'd0, words_loaded}, 32'd1);
    chk("mid_start_addr", imem_addr, 32'd4);
    start = 1'b0;
    for (int j = 1; j < 4; j++) push_byte(exp_words[1][8*(3 - j) +: 8]);
    chk("mid_start_done", {31'd0, done}, 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("mid_start_end_wl", {16'd0, words_loaded}, 32'd2);
    check_writes();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
